// File: rtl/fp32_pkg.sv
// Shared constants, FSM encoding and operand classification for the
// sequential single-precision multiplier.
package fp32_pkg;

    localparam int              FP_BIAS    = 127;
    localparam int              FP_EXP_MAX = 255;
    localparam logic [31:0]     FP_QNAN    = 32'h7FC0_0000;
    localparam int              FP_MANT_W  = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_MULT,
        ST_NORM,
        ST_PACK
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } op_class_t;

    // Denormals (exp == 0) deliberately fall into the zero class.
    function automatic op_class_t classify(input logic [31:0] f);
        if (f[30:23] == 8'h00) return CLS_ZERO;
        if (f[30:23] == 8'hFF) return (f[22:0] == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/mant_mul_seq.sv
// Iterative 24x24 unsigned shift-add multiplier retiring ITER_BITS
// multiplier bits per clock; valid pulses when the 48-bit product is final.
module mant_mul_seq #(
    parameter int ITER_BITS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic        busy,
    output logic        valid,
    output logic [47:0] p
);

    localparam int         N      = 24 / ITER_BITS;
    localparam logic [4:0] N_ITER = 5'(N);

    logic [47:0] mcand;
    logic [23:0] mplier;
    logic [4:0]  remaining;
    logic [47:0] partial;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        partial = '0;
        for (int j = 0; j < ITER_BITS; j++) begin
            if (mplier[j]) partial = partial + (mcand << j);
        end
    end

    assign busy = (remaining != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand     <= '0;
            mplier    <= '0;
            p         <= '0;
            remaining <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (load) begin
                mcand     <= {24'd0, a};
                mplier    <= b;
                p         <= '0;
                remaining <= N_ITER;
            end else if (busy) begin
                p         <= p + partial;
                mcand     <= mcand << ITER_BITS;
                mplier    <= mplier >> ITER_BITS;
                remaining <= remaining - 5'd1;
                valid     <= (remaining == 5'd1);
            end
        end
    end

endmodule

// File: rtl/fp32_mult_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier with fixed latency N+3
// from the accepting edge; flushes denormal results to zero.
module fp32_mult_seq
    import fp32_pkg::*;
#(
    parameter int ITER_BITS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] float1,
    input  logic [31:0] float2,
    input  logic        start,
    output logic [31:0] product,
    output logic        overflow,
    output logic        underflow,
    output logic        done,
    output logic        busy
);

    localparam logic signed [9:0] BIAS_S    = 10'(FP_BIAS);
    localparam logic signed [9:0] EXP_MAX_S = 10'(FP_EXP_MAX);

    state_t               state;
    logic [31:0]          op_a;
    logic [31:0]          op_b;
    op_class_t            cls_a;
    op_class_t            cls_b;
    logic                 sign;
    logic signed [9:0]    exp_e;
    logic [FP_MANT_W-1:0] mant;
    logic                 guard;
    logic                 sticky;

    logic                 accept;
    logic                 mul_busy;
    logic                 mul_valid;
    logic [47:0]          mul_p;

    logic                 round_up;
    logic [FP_MANT_W:0]   mant_rnd;
    logic signed [9:0]    exp_rnd;
    logic                 is_nan;
    logic                 any_inf;
    logic                 any_zero;

    assign accept = (state == ST_IDLE) && start && !mul_busy;

    // The multiplier is loaded straight from the ports on the accepting edge,
    // so it finishes exactly as the FSM leaves MULT.
    mant_mul_seq #(
        .ITER_BITS (ITER_BITS)
    ) u_mant_mul (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .a     ({|float1[30:23], float1[22:0]}),
        .b     ({|float2[30:23], float2[22:0]}),
        .busy  (mul_busy),
        .valid (mul_valid),
        .p     (mul_p)
    );

    always_comb begin
        round_up = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {{FP_MANT_W{1'b0}}, round_up};
        exp_rnd  = exp_e + $signed({9'd0, mant_rnd[FP_MANT_W]});
        is_nan   = (cls_a == CLS_NAN) || (cls_b == CLS_NAN)
                || (cls_a == CLS_INF && cls_b == CLS_ZERO)
                || (cls_a == CLS_ZERO && cls_b == CLS_INF);
        any_inf  = (cls_a == CLS_INF) || (cls_b == CLS_INF);
        any_zero = (cls_a == CLS_ZERO) || (cls_b == CLS_ZERO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            cls_a     <= CLS_ZERO;
            cls_b     <= CLS_ZERO;
            sign      <= 1'b0;
            exp_e     <= '0;
            mant      <= '0;
            guard     <= 1'b0;
            sticky    <= 1'b0;
            product   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= accept;
                    if (accept) begin
                        op_a  <= float1;
                        op_b  <= float2;
                        state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    sign  <= op_a[31] ^ op_b[31];
                    cls_a <= classify(op_a);
                    cls_b <= classify(op_b);
                    exp_e <= $signed({2'b00, op_a[30:23]}) + $signed({2'b00, op_b[30:23]}) - BIAS_S;
                    state <= ST_MULT;
                end
                ST_MULT: begin
                    if (mul_valid) state <= ST_NORM;
                end
                ST_NORM: begin
                    if (mul_p[47]) begin
                        mant   <= mul_p[46:24];
                        guard  <= mul_p[23];
                        sticky <= |mul_p[22:0];
                        exp_e  <= exp_e + 10'sd1;
                    end else begin
                        mant   <= mul_p[45:23];
                        guard  <= mul_p[22];
                        sticky <= |mul_p[21:0];
                    end
                    state <= ST_PACK;
                end
                ST_PACK: begin
                    done      <= 1'b1;
                    state     <= ST_IDLE;
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                    if (is_nan) begin
                        product <= FP_QNAN;
                    end else if (any_inf) begin
                        product <= {sign, 8'hFF, 23'd0};
                    end else if (any_zero) begin
                        product <= {sign, 31'd0};
                    end else if (exp_rnd >= EXP_MAX_S) begin
                        product  <= {sign, 8'hFF, 23'd0};
                        overflow <= 1'b1;
                    end else if (exp_rnd <= 10'sd0) begin
                        product   <= {sign, 31'd0};
                        underflow <= 1'b1;
                    end else begin
                        product <= {sign, exp_rnd[7:0], mant_rnd[FP_MANT_W-1:0]};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_mult_seq.sv
// Randomised bench for fp32_mult_seq against an arithmetic reference model,
// plus directed special-case, ignored-start, back-to-back and reset scenarios.
`timescale 1ns/1ps
module tb_fp32_mult_seq;

    localparam int ITER_BITS = 1;
    localparam int N         = 24 / ITER_BITS;
    localparam int NDIR      = 8;

    typedef struct {
        logic [31:0] prod;
        logic        ov;
        logic        un;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] float1, float2;
    logic        start;
    logic [31:0] product;
    logic        overflow, underflow, done, busy;

    logic [31:0] float1_4, float2_4;
    logic        start4;
    logic [31:0] product4;
    logic        overflow4, underflow4, done4, busy4;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [31:0] held_prod = '0;
    logic        held_ov = 1'b0;
    logic        held_un = 1'b0;
    int          last_done_cyc = -1;
    bit          checking = 1'b0;

    logic [31:0] va   [NDIR] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h7F000000,
                                 32'h00800000, 32'h7F800000, 32'hFF800000, 32'h00000001};
    logic [31:0] vb   [NDIR] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h7F000000,
                                 32'h00800000, 32'h00000000, 32'h40000000, 32'h40000000};
    logic [33:0] vexp [NDIR] = '{34'h0_4040_0000, 34'h0_C0C0_0000, 34'h0_3F80_0002, 34'h2_7F80_0000,
                                 34'h1_0000_0000, 34'h0_7FC0_0000, 34'h0_FF80_0000, 34'h0_0000_0000};

    fp32_mult_seq #(.ITER_BITS(ITER_BITS)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .float1    (float1),
        .float2    (float2),
        .start     (start),
        .product   (product),
        .overflow  (overflow),
        .underflow (underflow),
        .done      (done),
        .busy      (busy)
    );

    fp32_mult_seq #(.ITER_BITS(4)) u_dut4 (
        .clock     (clock),
        .reset     (reset),
        .float1    (float1_4),
        .float2    (float2_4),
        .start     (start4),
        .product   (product4),
        .overflow  (overflow4),
        .underflow (underflow4),
        .done      (done4),
        .busy      (busy4)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Returns {overflow, underflow, product} from exact integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        int          ea, eb, e, shift;
        logic [63:0] ma, mb, p, q, rem, half;
        logic        za, zb, ia, ib, na, nb;
        sgn = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        za  = (ea == 0);
        zb  = (eb == 0);
        ia  = (ea == 255) && (a[22:0] == 23'd0);
        ib  = (eb == 255) && (b[22:0] == 23'd0);
        na  = (ea == 255) && (a[22:0] != 23'd0);
        nb  = (eb == 255) && (b[22:0] != 23'd0);
        if (na || nb || (ia && zb) || (za && ib)) return {2'b00, 32'h7FC00000};
        if (ia || ib) return {2'b00, sgn, 8'hFF, 23'd0};
        if (za || zb) return {2'b00, sgn, 31'd0};
        ma    = {40'd0, 1'b1, a[22:0]};
        mb    = {40'd0, 1'b1, b[22:0]};
        p     = ma * mb;
        shift = (p >= 64'h0000_8000_0000_0000) ? 24 : 23;
        q     = p >> shift;
        rem   = p - (q << shift);
        half  = 64'd1 << (shift - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        e = ea + eb - 127 + (shift - 23);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {2'b10, sgn, 8'hFF, 23'd0};
        if (e <= 0) return {2'b01, sgn, 31'd0};
        return {2'b00, sgn, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k = int'($urandom_range(0, 11));
        f = 23'($urandom);
        case (k)
            0:       begin e = 8'h00; f = 23'd0; end
            1:       e = 8'h00;
            2:       begin e = 8'hFF; f = 23'd0; end
            3:       begin e = 8'hFF; if (f == 23'd0) f = 23'd1; end
            4:       e = 8'($urandom_range(200, 254));
            5:       e = 8'($urandom_range(1, 40));
            6:       begin e = 8'($urandom_range(100, 150)); f = 23'h7FFFFF - 23'($urandom_range(0, 3)); end
            default: e = 8'($urandom_range(90, 164));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // Called on a falling edge; start is sampled on the following rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [33:0] m;
        #1;
        float1 = a;
        float2 = b;
        start  = 1'b1;
        m      = model(a, b);
        e.prod = m[31:0];
        e.ov   = m[33];
        e.un   = m[32];
        e.due  = cyc + 1 + N + 3;
        exp_q.push_back(e);
        @(negedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic stray(input logic [31:0] a, input logic [31:0] b);
        #1;
        float1 = a;
        float2 = b;
        start  = 1'b1;
        @(negedge clock);
        #1;
        start  = 1'b0;
        float1 = 32'($urandom);
        float2 = 32'($urandom);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (done) return;
        end
        n_checks++;
        n_err++;
        $display("FAIL wait_done: no done within 200 cycles (cycle %0d)", cyc);
    endtask

    always @(negedge clock) begin
        if (checking) begin
            logic exp_done;
            exp_done = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("done", 34'(done), 34'(exp_done));
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                held_prod     = exp_q[0].prod;
                held_ov       = exp_q[0].ov;
                held_un       = exp_q[0].un;
                last_done_cyc = cyc;
                void'(exp_q.pop_front());
            end
            check("product", 34'(product), 34'(held_prod));
            check("overflow", 34'(overflow), 34'(held_ov));
            check("underflow", 34'(underflow), 34'(held_un));
            if (exp_q.size() > 0 && cyc < exp_q[0].due)
                check("busy", 34'(busy), 34'd1);
            else if (exp_q.size() == 0 && cyc != last_done_cyc)
                check("busy", 34'(busy), 34'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, lat;
        float1   = '0;
        float2   = '0;
        start    = 1'b0;
        float1_4 = '0;
        float2_4 = '0;
        start4   = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clock);
        checking = 1'b1;

        for (int i = 0; i < NDIR; i++)
            check($sformatf("model_%0d", i), model(va[i], vb[i]), vexp[i]);

        #1 reset = 1'b0;
        @(negedge clock);

        // Directed vectors, each started in the done cycle of the previous one.
        for (int i = 0; i < NDIR; i++) begin
            issue(va[i], vb[i]);
            wait_done();
        end

        // A second start five cycles in must be ignored.
        issue(32'h3FC00000, 32'h40000000);
        repeat (3) @(negedge clock);
        stray(32'h40400000, 32'h40400000);
        wait_done();

        // Reset at cycle 10 aborts without a done; the next operation completes.
        issue(32'hC0000000, 32'h40400000);
        repeat (8) @(negedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        held_prod = '0;
        held_ov   = 1'b0;
        held_un   = 1'b0;
        @(negedge clock);
        check("rst_busy", 34'(busy), 34'd0);
        check("rst_product", 34'(product), 34'd0);
        #1 reset = 1'b0;
        @(negedge clock);
        issue(32'h3FC00000, 32'h40000000);
        wait_done();

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            issue(rand_float(), rand_float());
            wait_done();
        end

        // Four bits per cycle: done nine cycles after the accepting edge.
        @(negedge clock);
        #1;
        float1_4 = 32'h3FC00000;
        float2_4 = 32'h40000000;
        start4   = 1'b1;
        t0       = cyc + 1;
        @(negedge clock);
        #1 start4 = 1'b0;
        check("busy4", 34'(busy4), 34'd1);
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (done4) begin
                lat = cyc - t0;
                break;
            end
        end
        check("latency4", 34'(lat), 34'd9);
        check("product4", {overflow4, underflow4, product4}, 34'h0_4040_0000);

        repeat (5) @(negedge clock);
        check("queue_drained", 34'(exp_q.size()), 34'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
